// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO AXI4-Lite write slave.
//   - Register index constants for the write register map
//   - AXI write response codes
//   - Write-channel FSM state type
//   - Helper that expands byte strobes into a per-bit write mask
package gpio_pkg;

   localparam logic [31:0] IDX_DATA = 32'd0;
   localparam logic [31:0] IDX_DIR  = 32'd1;
   localparam logic [31:0] IDX_SET  = 32'd2;
   localparam logic [31:0] IDX_CLR  = 32'd3;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      StIdle,
      StWaitW,
      StWaitAw,
      StExec,
      StResp
   } gpio_state_e;

   // Every bit of byte lane b follows strobe bit b.
   function automatic logic [31:0] strb_mask(input logic [3:0] strb);
      logic [31:0] mask;
      mask = '0;
      for (int b = 0; b < 4; b++) begin
         mask[b*8 +: 8] = {8{strb[b]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/gpio_wr_regfile.sv
// GPIO output-data and direction registers.
// Applies a strobe-masked DATA/DIR/SET/CLR operation when we_i is high for
// one cycle; the result is visible on the outputs the following cycle.
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   we_i           one-cycle write enable (valid index only)
//   op_i           low two bits of the register index
//   data_i         raw write data (only [NPINS-1:0] used)
//   strb_i         byte strobes
//   gpio_out_o     output-data register
//   gpio_oe_o      direction register (1 = drive)
module gpio_wr_regfile
   import gpio_pkg::*;
#(
   parameter int unsigned NPINS = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             we_i,
   input  logic [1:0]       op_i,
   input  logic [31:0]      data_i,
   input  logic [3:0]       strb_i,
   output logic [NPINS-1:0] gpio_out_o,
   output logic [NPINS-1:0] gpio_oe_o
);

   logic [NPINS-1:0] gpio_out_q, gpio_out_d;
   logic [NPINS-1:0] gpio_oe_q, gpio_oe_d;
   logic [31:0]      mask_full;
   logic [NPINS-1:0] mask;
   logic [NPINS-1:0] wdata;
   logic [NPINS-1:0] wbits;

   assign mask_full = strb_mask(strb_i);
   assign mask      = mask_full[NPINS-1:0];
   assign wdata     = data_i[NPINS-1:0];
   // Data bits that are both strobed and set.
   assign wbits     = wdata & mask;

   // Bits above NPINS are intentionally ignored.
   logic unused_bits;
   assign unused_bits = ^{mask_full, data_i};

   always_comb begin
      gpio_out_d = gpio_out_q;
      gpio_oe_d  = gpio_oe_q;
      if (we_i) begin
         unique case (op_i)
            IDX_DATA[1:0]: gpio_out_d = (gpio_out_q & ~mask) | wbits;
            IDX_DIR[1:0]:  gpio_oe_d  = (gpio_oe_q & ~mask) | wbits;
            IDX_SET[1:0]:  gpio_out_d = gpio_out_q | wbits;
            IDX_CLR[1:0]:  gpio_out_d = gpio_out_q & ~wbits;
            default:       gpio_out_d = gpio_out_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         gpio_out_q <= '0;
         gpio_oe_q  <= '0;
      end else begin
         gpio_out_q <= gpio_out_d;
         gpio_oe_q  <= gpio_oe_d;
      end
   end

   assign gpio_out_o = gpio_out_q;
   assign gpio_oe_o  = gpio_oe_q;

endmodule

// File: rtl/gpio_axi_wr_slave.sv
// AXI4-Lite write-channel slave for the GPIO peripheral.
// Accepts AW and W in either order (or together), executes one register
// write in a single EXEC cycle, then holds the B response until accepted.
// One transaction in flight at a time.
// Ports:
//   clock, reset                 system clock, synchronous active-high reset
//   AWvalid/AWready/AWaddr       write-address channel (index = AWaddr[IDX_BITS-1:0])
//   Wvalid/Wready/Wdata/Wstrb    write-data channel
//   Bvalid/Bready/Bresp          write-response channel
//   gpio_out, gpio_oe            GPIO output-data and direction registers
//   wr_pulse                     one-cycle strobe when a register is updated
module gpio_axi_wr_slave
   import gpio_pkg::*;
#(
   parameter int unsigned NPINS    = 8,
   parameter int unsigned IDX_BITS = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             AWvalid,
   output logic             AWready,
   input  logic [31:0]      AWaddr,
   input  logic             Wvalid,
   output logic             Wready,
   input  logic [31:0]      Wdata,
   input  logic [3:0]       Wstrb,
   output logic             Bvalid,
   input  logic             Bready,
   output logic [1:0]       Bresp,
   output logic [NPINS-1:0] gpio_out,
   output logic [NPINS-1:0] gpio_oe,
   output logic             wr_pulse
);

   gpio_state_e         state_q, state_d;
   logic [IDX_BITS-1:0] idx_q, idx_d;
   logic [31:0]         data_q, data_d;
   logic [3:0]          strb_q, strb_d;
   logic                bvalid_q, bvalid_d;
   logic [1:0]          bresp_q, bresp_d;
   logic                reg_we;
   logic [31:0]         idx_ext;
   logic                idx_valid;

   assign idx_ext   = 32'(idx_q);
   assign idx_valid = (idx_ext <= IDX_CLR);

   // Address bits above the index alias by design.
   logic unused_addr;
   assign unused_addr = ^AWaddr;

   // Readies decode registered state only, forced low during reset.
   assign AWready = !reset && ((state_q == StIdle) || (state_q == StWaitAw));
   assign Wready  = !reset && ((state_q == StIdle) || (state_q == StWaitW));

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      data_d   = data_q;
      strb_d   = strb_q;
      bvalid_d = bvalid_q;
      bresp_d  = bresp_q;
      reg_we   = 1'b0;
      wr_pulse = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (AWvalid && Wvalid) begin
               idx_d   = AWaddr[IDX_BITS-1:0];
               data_d  = Wdata;
               strb_d  = Wstrb;
               state_d = StExec;
            end else if (AWvalid) begin
               idx_d   = AWaddr[IDX_BITS-1:0];
               state_d = StWaitW;
            end else if (Wvalid) begin
               data_d  = Wdata;
               strb_d  = Wstrb;
               state_d = StWaitAw;
            end
         end
         StWaitW: begin
            if (Wvalid) begin
               data_d  = Wdata;
               strb_d  = Wstrb;
               state_d = StExec;
            end
         end
         StWaitAw: begin
            if (AWvalid) begin
               idx_d   = AWaddr[IDX_BITS-1:0];
               state_d = StExec;
            end
         end
         StExec: begin
            reg_we   = idx_valid;
            wr_pulse = idx_valid;
            bresp_d  = idx_valid ? RESP_OKAY : RESP_SLVERR;
            bvalid_d = 1'b1;
            state_d  = StResp;
         end
         StResp: begin
            if (Bready) begin
               bvalid_d = 1'b0;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         data_q   <= '0;
         strb_q   <= '0;
         bvalid_q <= 1'b0;
         bresp_q  <= RESP_OKAY;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         data_q   <= data_d;
         strb_q   <= strb_d;
         bvalid_q <= bvalid_d;
         bresp_q  <= bresp_d;
      end
   end

   assign Bvalid = bvalid_q;
   assign Bresp  = bresp_q;

   gpio_wr_regfile #(
      .NPINS (NPINS)
   ) u_regfile (
      .clock      (clock),
      .reset      (reset),
      .we_i       (reg_we),
      .op_i       (idx_ext[1:0]),
      .data_i     (data_q),
      .strb_i     (strb_q),
      .gpio_out_o (gpio_out),
      .gpio_oe_o  (gpio_oe)
   );

endmodule

// File: tb/tb_gpio_axi_wr_slave.sv
// Directed self-checking bench for gpio_axi_wr_slave (NPINS=8, IDX_BITS=3).
module tb_gpio_axi_wr_slave;

   logic        clock = 1'b0;
   logic        reset;
   logic        AWvalid, AWready;
   logic [31:0] AWaddr;
   logic        Wvalid, Wready;
   logic [31:0] Wdata;
   logic [3:0]  Wstrb;
   logic        Bvalid, Bready;
   logic [1:0]  Bresp;
   logic [7:0]  gpio_out, gpio_oe;
   logic        wr_pulse;

   int n_tests = 0;
   int n_fail  = 0;
   int b_count = 0;
   int p_count = 0;
   int bv_seen = 0;

   always #5 clock = ~clock;

   gpio_axi_wr_slave #(
      .NPINS    (8),
      .IDX_BITS (3)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .AWvalid  (AWvalid),
      .AWready  (AWready),
      .AWaddr   (AWaddr),
      .Wvalid   (Wvalid),
      .Wready   (Wready),
      .Wdata    (Wdata),
      .Wstrb    (Wstrb),
      .Bvalid   (Bvalid),
      .Bready   (Bready),
      .Bresp    (Bresp),
      .gpio_out (gpio_out),
      .gpio_oe  (gpio_oe),
      .wr_pulse (wr_pulse)
   );

   always @(posedge clock) begin
      if (Bvalid && Bready) b_count <= b_count + 1;
      if (wr_pulse)         p_count <= p_count + 1;
      if (Bvalid)           bv_seen <= bv_seen + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; return 1 time unit after the edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Simultaneous AW+W write with Bready high; returns the response.
   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
      int n;
      AWaddr  = addr;
      Wdata   = data;
      Wstrb   = strb;
      AWvalid = 1'b1;
      Wvalid  = 1'b1;
      Bready  = 1'b1;
      step();
      AWvalid = 1'b0;
      Wvalid  = 1'b0;
      n = 0;
      while (!Bvalid && n < 8) begin
         step();
         n++;
      end
      check_eq("bvalid_timeout", 32'(Bvalid), 32'd1);
      resp = Bresp;
      step();
      Bready = 1'b0;
   endtask

   logic [1:0] resp;
   int         b0, p0;

   initial begin
      reset   = 1'b1;
      AWvalid = 1'b0;
      AWaddr  = '0;
      Wvalid  = 1'b0;
      Wdata   = '0;
      Wstrb   = '0;
      Bready  = 1'b0;
      step();
      step();
      check_eq("rst_awready", 32'(AWready), 32'd0);
      check_eq("rst_wready", 32'(Wready), 32'd0);
      reset = 1'b0;
      #1;
      check_eq("rst_gpio_out", 32'(gpio_out), 32'h0);
      check_eq("rst_gpio_oe", 32'(gpio_oe), 32'h0);
      check_eq("rst_bvalid", 32'(Bvalid), 32'd0);
      check_eq("rst_bresp", 32'(Bresp), 32'd0);
      check_eq("rst_wr_pulse", 32'(wr_pulse), 32'd0);
      check_eq("idle_awready", 32'(AWready), 32'd1);

      // 1: simultaneous AW+W, cycle-accurate latency
      AWaddr = 32'h0; Wdata = 32'hA5; Wstrb = 4'hF;
      AWvalid = 1'b1; Wvalid = 1'b1; Bready = 1'b1;
      step();                                    // cycle 1: EXEC
      AWvalid = 1'b0; Wvalid = 1'b0;
      check_eq("t1_pulse_c1", 32'(wr_pulse), 32'd1);
      check_eq("t1_awready_c1", 32'(AWready), 32'd0);
      check_eq("t1_bvalid_c1", 32'(Bvalid), 32'd0);
      check_eq("t1_out_c1", 32'(gpio_out), 32'h0);
      step();                                    // cycle 2: RESP
      check_eq("t1_out_c2", 32'(gpio_out), 32'hA5);
      check_eq("t1_bvalid_c2", 32'(Bvalid), 32'd1);
      check_eq("t1_bresp_c2", 32'(Bresp), 32'd0);
      check_eq("t1_pulse_c2", 32'(wr_pulse), 32'd0);
      step();                                    // cycle 3: IDLE
      check_eq("t1_awready_c3", 32'(AWready), 32'd1);
      check_eq("t1_bvalid_c3", 32'(Bvalid), 32'd0);
      Bready = 1'b0;

      // 2: data before address
      Wdata = 32'h0F; Wstrb = 4'hF; Wvalid = 1'b1;
      check_eq("t2_wready_c0", 32'(Wready), 32'd1);
      step();                                    // WAIT_AW
      Wvalid = 1'b0;
      check_eq("t2_awready_waitaw", 32'(AWready), 32'd1);
      check_eq("t2_wready_waitaw", 32'(Wready), 32'd0);
      step();
      step();
      AWaddr = 32'h1; AWvalid = 1'b1;
      step();                                    // EXEC
      AWvalid = 1'b0;
      check_eq("t2_awready_exec", 32'(AWready), 32'd0);
      step();                                    // RESP
      check_eq("t2_awready_resp", 32'(AWready), 32'd0);
      check_eq("t2_gpio_oe", 32'(gpio_oe), 32'h0F);
      check_eq("t2_gpio_out", 32'(gpio_out), 32'hA5);
      check_eq("t2_bresp", 32'(Bresp), 32'd0);
      Bready = 1'b1;
      step();
      Bready = 1'b0;
      check_eq("t2_idle", 32'(AWready), 32'd1);

      // 3: DATA / SET / CLR, one B response each
      b0 = b_count;
      do_write(32'h0, 32'hF0, 4'hF, resp);
      check_eq("t3_data", 32'(gpio_out), 32'hF0);
      do_write(32'h2, 32'h03, 4'hF, resp);
      check_eq("t3_set", 32'(gpio_out), 32'hF3);
      check_eq("t3_set_resp", 32'(resp), 32'd0);
      do_write(32'h3, 32'h30, 4'hF, resp);
      check_eq("t3_clr", 32'(gpio_out), 32'hC3);
      check_eq("t3_bcount", 32'(b_count - b0), 32'd3);

      // strobes: all-zero and lane-0-off leave the register alone
      p0 = p_count;
      do_write(32'h0, 32'hFF, 4'h0, resp);
      check_eq("strb0_out", 32'(gpio_out), 32'hC3);
      check_eq("strb0_resp", 32'(resp), 32'd0);
      check_eq("strb0_pulse", 32'(p_count - p0), 32'd1);
      do_write(32'h1, 32'hFF, 4'hE, resp);
      check_eq("strbE_oe", 32'(gpio_oe), 32'h0F);
      // high data bits ignored, upper address bits alias
      do_write(32'h0, 32'hFFFF_FF00, 4'hF, resp);
      check_eq("hi_data_out", 32'(gpio_out), 32'h00);
      do_write(32'h108, 32'h5A, 4'hF, resp);
      check_eq("alias_out", 32'(gpio_out), 32'h5A);

      // 4: reserved index
      p0 = p_count;
      do_write(32'h5, 32'hFF, 4'hF, resp);
      check_eq("t4_out", 32'(gpio_out), 32'h5A);
      check_eq("t4_oe", 32'(gpio_oe), 32'h0F);
      check_eq("t4_pulse", 32'(p_count - p0), 32'd0);
      check_eq("t4_resp", 32'(resp), 32'h2);

      // 5: B backpressure (reserved index so Bresp is non-zero)
      AWaddr = 32'h6; Wdata = 32'h11; Wstrb = 4'hF;
      AWvalid = 1'b1; Wvalid = 1'b1; Bready = 1'b0;
      step();
      AWvalid = 1'b0; Wvalid = 1'b0;
      step();
      for (int i = 0; i < 10; i++) begin
         check_eq("t5_bvalid_hold", 32'(Bvalid), 32'd1);
         check_eq("t5_bresp_hold", 32'(Bresp), 32'h2);
         check_eq("t5_awready_hold", 32'(AWready), 32'd0);
         check_eq("t5_wready_hold", 32'(Wready), 32'd0);
         step();
      end
      Bready = 1'b1;
      step();
      Bready = 1'b0;
      check_eq("t5_bvalid_drop", 32'(Bvalid), 32'd0);
      check_eq("t5_out", 32'(gpio_out), 32'h5A);

      // 6: reset while in WAIT_W aborts the write
      AWaddr = 32'h0; AWvalid = 1'b1; Bready = 1'b1;
      step();                                    // WAIT_W
      AWvalid = 1'b0;
      check_eq("t6_wready_waitw", 32'(Wready), 32'd1);
      check_eq("t6_awready_waitw", 32'(AWready), 32'd0);
      reset = 1'b1;
      #1;
      check_eq("t6_awready_inrst", 32'(AWready), 32'd0);
      check_eq("t6_wready_inrst", 32'(Wready), 32'd0);
      step();
      reset = 1'b0;
      #1;
      bv_seen = 0;
      check_eq("t6_out", 32'(gpio_out), 32'h0);
      check_eq("t6_oe", 32'(gpio_oe), 32'h0);
      check_eq("t6_bvalid", 32'(Bvalid), 32'd0);
      check_eq("t6_bresp", 32'(Bresp), 32'd0);
      check_eq("t6_idle_awready", 32'(AWready), 32'd1);
      // Data arriving now must start a fresh transaction, not complete the old one.
      Wdata = 32'h77; Wstrb = 4'hF; Wvalid = 1'b1;
      step();
      Wvalid = 1'b0;
      for (int i = 0; i < 5; i++) step();
      check_eq("t6_no_bvalid", 32'(bv_seen), 32'd0);
      check_eq("t6_out_after", 32'(gpio_out), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/gpio_axi_wr_slave.md
Name: gpio_axi_wr_slave

Overview:
- AXI4-Lite write-channel slave for the GPIO peripheral; sits directly downstream of the AXI interconnect and upstream of the GPIO pin drivers.
- Runs the AW/W/B handshakes and captures the 3-bit register index from the write address.
- Applies write data to the GPIO output-data and direction registers, then returns a write response.

Parameters:
- NPINS, 8, number of GPIO pins (1..32); width of gpio_out/gpio_oe.
- IDX_BITS, 3, number of low address bits used as register index.

Ports:
- clock  in  1  single system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- AWvalid  in  1  write-address valid
- AWready  out  1  write-address ready
- AWaddr  in  32  write address; only [IDX_BITS-1:0] used
- Wvalid  in  1  write-data valid
- Wready  out  1  write-data ready
- Wdata  in  32  write data; only [NPINS-1:0] used
- Wstrb  in  4  byte strobes
- Bvalid  out  1  write-response valid
- Bready  in  1  write-response ready
- Bresp  out  2  2'b00 OKAY, 2'b10 SLVERR
- gpio_out  out  NPINS  output-data register
- gpio_oe  out  NPINS  direction register (1 = drive)
- wr_pulse  out  1  one-cycle strobe when a register is updated

Behaviour:
- Reset, synchronous and active-high, takes effect on the clock edge where reset=1:
  - state goes to IDLE
  - gpio_out=0, gpio_oe=0, Bvalid=0, Bresp=00, wr_pulse=0
  - latched index and data are cleared
  - AWready=Wready=0 while reset is high
- A reset asserted mid-transaction aborts it; no B response is ever issued for that transaction.
- Register map, index = AWaddr[2:0]:
  - 0 DATA: gpio_out <= Wdata
  - 1 DIR: gpio_oe <= Wdata
  - 2 SET: gpio_out <= gpio_out | Wdata
  - 3 CLR: gpio_out <= gpio_out & ~Wdata
  - 4..7 reserved: no update, Bresp=SLVERR
- Wstrb rules:
  - Bits [NPINS-1:0] of Wdata are gated by Wstrb per byte.
  - A byte with strobe 0 leaves the corresponding register bits unchanged.
  - All-zero Wstrb to a valid index: no change, Bresp=OKAY, wr_pulse still fires.
- FSM states: IDLE, WAIT_W, WAIT_AW, EXEC, RESP.
  - AWready = state is IDLE or WAIT_AW (decoded from registered state).
  - Wready = state is IDLE or WAIT_W.
- IDLE transitions:
  - AWvalid and Wvalid -> latch both -> EXEC.
  - AWvalid only -> latch index -> WAIT_W.
  - Wvalid only -> latch Wdata/Wstrb -> WAIT_AW.
- WAIT_W: Wvalid -> latch data -> EXEC.
- WAIT_AW: AWvalid -> latch index -> EXEC.
- EXEC (exactly one cycle):
  - Update the target register, effective next cycle.
  - wr_pulse=1 for valid indices only.
  - Set Bresp.
  - Bvalid <= 1 and go to RESP.
- RESP:
  - Hold Bvalid and Bresp stable until Bready=1.
  - On that handshake edge, Bvalid <= 0 and go to IDLE.
  - Bready=1 on the same cycle Bvalid rises completes the handshake at that edge.
- Latency, simultaneous AW+W accepted in cycle 0:
  - EXEC in cycle 1, register value visible in cycle 2.
  - Bvalid=1 in cycle 2.
  - With Bready held high, back in IDLE in cycle 3 and ready for the next transaction.
- Max throughput: one write per 3 cycles. No outstanding-transaction pipelining.
- Valids arriving during EXEC or RESP are not accepted (ready=0). Masters must hold them, per AXI rules.
- Bits of Wdata above NPINS are ignored. Address bits above IDX_BITS are ignored (aliasing is intended).

Decomposition:
- Shared package gpio_pkg holds:
  - register index constants IDX_DATA=0, IDX_DIR=1, IDX_SET=2, IDX_CLR=3
  - response codes RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - FSM state enum
- One natural sub-module: gpio_wr_regfile. It holds gpio_out and gpio_oe and applies the strobe-masked DATA/DIR/SET/CLR operation on a one-cycle write enable from the FSM.

Test Plan:
1. Reset, then AWaddr=0, Wdata=0xA5, Wstrb=0xF together in cycle 0, Bready=1 -> gpio_out=0xA5 in cycle 2, Bvalid=1 and Bresp=00 in cycle 2, wr_pulse in cycle 1, AWready=1 again in cycle 3.
2. Data before address: Wvalid with 0x0F in cycle 0, AWvalid with addr=1 in cycle 3 -> AWready=0 only while in EXEC/RESP, gpio_oe=0x0F, Bresp=00.
3. gpio_out=0xF0; SET with 0x03 -> 0xF3; CLR with 0x30 -> 0xC3; each write gets exactly one B response.
4. AWaddr=5 with Wdata=0xFF -> gpio_out and gpio_oe unchanged, wr_pulse=0, Bresp=2'b10.
5. Bready held low 10 cycles after Bvalid -> Bvalid and Bresp stable, AWready=Wready=0 throughout; Bready=1 -> Bvalid=0 next cycle.
6. Reset in WAIT_W (addr latched, no data) -> next cycle state IDLE, all outputs 0, no Bvalid ever produced for the aborted write.
